data_mem_arbiter: RTL
=====================

# data_mem_arbiter

Two-port round-robin arbiter that shares one `data_mem` instance between two requesters, e.g. core load/store unit and a DMA/debug port. It sits between the requesters and `data_mem` and speaks the same flattened `mem_in_s`/`mem_out_s` valid/yumi handshake on every side. It serialises one complete memory transaction at a time: request, memory response, requester acknowledge.

## Interface
- `addr_width_p`, 12, byte-address width, identical to the attached `data_mem`
- `clk`  in  1  single clock, all state on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state immediately
- `req0_flat_i`  in  $bits(mem_in_s)  requester 0 request: valid, wen, byte_not_word, write_data, yumi
- `req0_addr_i`  in  addr_width_p  requester 0 byte address
- `req0_flat_o`  out  $bits(mem_out_s)  requester 0 response: valid, read_data, yumi
- `req1_flat_i`, `req1_addr_i`, `req1_flat_o`  same as requester 0
- `mem_flat_o`  out  $bits(mem_in_s)  to `data_mem` `port_flat_i`
- `mem_addr_o`  out  addr_width_p  to `data_mem` `addr`
- `mem_flat_i`  in  $bits(mem_out_s)  from `data_mem` `port_flat_o`
- `grant_o`  out  2  one-hot current owner; 2'b00 when IDLE

## Operation
- State `state_r`: IDLE, ISSUE, WAIT, RETURN. Registers: `owner_r` (1 bit), `last_r` (1 bit, last served), latched `addr_r`, `wen_r`, `bnw_r`, `wdata_r`, `rdata_r`.
- IDLE: if any `reqN.valid`, choose the winner. If only one is valid, it wins. If both are valid, requester `!last_r` wins. Winner's `reqN_flat_o.yumi`=1, combinational, same cycle. Latch its addr/wen/byte_not_word/write_data and set `owner_r`, then go to ISSUE. Loser's yumi=0; the loser must hold its request.
- ISSUE: `mem.valid`=1 with latched fields on `mem_flat_o` and `mem_addr_o`. When `mem_flat_i.yumi`=1, go to WAIT. Otherwise stay in ISSUE, holding all fields.
- WAIT: `mem.valid`=0. When `mem_flat_i.valid`=1, drive `mem_flat_o.yumi`=1 in the same cycle. If `wen_r`=0, capture `rdata_r`<=`mem_flat_i.read_data`; if `wen_r`=1, `rdata_r`<=0. Then go to RETURN.
- RETURN: owner's `reqN_flat_o.valid`=1 and `read_data`=`rdata_r`, both held until the owner's `reqN_flat_i.yumi`=1. On that yumi: `last_r`<=`owner_r`, go to IDLE.
- Byte reads return zero-extended data exactly as memory supplies it. The arbiter does no width manipulation and does no address wrap; addresses pass through unchanged.
- The non-owner's `reqN_flat_o` stays all-zero throughout a transaction. Requester yumi inputs are ignored outside RETURN. The requester `valid` input is ignored outside IDLE.
- `mem_flat_o.yumi` is 1 only in WAIT with memory valid. Outside ISSUE, `mem_flat_o.valid`=0 and the data fields hold their latched values.

## Timing
- Reset values: `state_r`=IDLE, `last_r`=1 (requester 0 wins first tie), `owner_r`=0, all latched data 0. Every output is 0: both valids, all yumis, read_data, `grant_o`.
- Minimum transaction with zero-latency memory and immediate requester yumi: accept at cycle 0, ISSUE at cycle 1, WAIT sees memory valid at cycle 2, requester valid at cycle 3. A new grant is possible at cycle 4.
- Memory stalls (yumi late in ISSUE, valid late in WAIT) and requester stalls in RETURN extend the transaction indefinitely. No timeout.
- Requester yumi and `mem_flat_o.yumi` are combinational from inputs. All valids and data are registered-state-derived.
- Reset mid-transaction: state returns to IDLE asynchronously and the in-flight response is discarded. The system resets `data_mem` in the same window.

## Structure
- Add enum `arb_state_e` {IDLE, ISSUE, WAIT, RETURN} to the shared definitions package alongside `mem_in_s`/`mem_out_s`. Add no new structs.
- One sub-module, `rr_pick2`: combinational 2-way round-robin picker (inputs valid[1:0], last; outputs grant one-hot, any). All remaining logic stays in `data_mem_arbiter`.

## Test plan
- Reset, then req0 word write 0xDEADBEEF @0x010 → req0 yumi at cycle 0, mem valid at cycle 1, req0 response valid at cycle 3 with read_data 0. Then req0 word read @0x010 → read_data 0xDEADBEEF.
- req0 and req1 both valid every cycle, 4 transactions → grants alternate 0,1,0,1. The first goes to req0 after reset. `grant_o` stays one-hot and never changes mid-transaction.
- req1 byte read @0x011 after word write 0x11223344 @0x010 → read_data 0x00000033.
- Requester holds yumi low 5 cycles in RETURN → response valid/data held stable. The other requester's pending valid is not accepted until after the yumi.
- Assert reset during WAIT → all outputs 0 asynchronously. After release, a fresh req1 read completes normally.

Source files
------------

// File: rtl/data_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_arbiter_pkg
// Description : Shared definitions for the data_mem port handshake and the
//               arbiter state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package data_mem_arbiter_pkg;

  localparam int unsigned DATA_W = 32;

  // Request side of a data_mem port (MSB first: valid ... yumi).
  typedef struct packed {
    logic              valid;
    logic              wen;
    logic              byte_not_word;
    logic [DATA_W-1:0] write_data;
    logic              yumi;
  } mem_in_s;

  // Response side of a data_mem port.
  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] read_data;
    logic              yumi;
  } mem_out_s;

  // Arbiter transaction phase.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT   = 2'd2,
    RETURN = 2'd3
  } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/data_mem_arbiter_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick2
// Description : Combinational two-way round-robin picker. On a tie the
//               requester that was not served last wins.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick2 (
  input  logic [1:0] valid_i,
  input  logic       last_i,
  output logic [1:0] grant_o,
  output logic       any_o
);

  // One-hot winner selection; a tie is broken against the last-served side.
  always_comb begin
    grant_o = 2'b00;
    case (valid_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = last_i ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
  end

  assign any_o = |valid_i;

endmodule
`default_nettype wire

// File: rtl/data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_arbiter
// Description : Round-robin arbiter sharing one data_mem between two
//               requesters. One complete transaction (request, memory
//               response, requester acknowledge) is in flight at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int unsigned addr_width_p = 12
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [$bits(mem_in_s)-1:0]   req0_flat_i,
  input  logic [addr_width_p-1:0]      req0_addr_i,
  output logic [$bits(mem_out_s)-1:0]  req0_flat_o,
  input  logic [$bits(mem_in_s)-1:0]   req1_flat_i,
  input  logic [addr_width_p-1:0]      req1_addr_i,
  output logic [$bits(mem_out_s)-1:0]  req1_flat_o,
  output logic [$bits(mem_in_s)-1:0]   mem_flat_o,
  output logic [addr_width_p-1:0]      mem_addr_o,
  input  logic [$bits(mem_out_s)-1:0]  mem_flat_i,
  output logic [1:0]                   grant_o
);

  mem_in_s  req0_in;
  mem_in_s  req1_in;
  mem_out_s mem_rsp;

  assign req0_in = req0_flat_i;
  assign req1_in = req1_flat_i;
  assign mem_rsp = mem_flat_i;

  arb_state_e               state_q;
  logic                     owner_q;
  logic                     last_q;
  logic [addr_width_p-1:0]  addr_q;
  logic                     wen_q;
  logic                     bnw_q;
  logic [DATA_W-1:0]        wdata_q;
  logic [DATA_W-1:0]        rdata_q;
  logic [DATA_W-1:0]        rdata_d;

  logic [1:0]               pick_valid;
  logic [1:0]               pick_grant;
  logic                     pick_any;

  // Request valids only matter while IDLE; elsewhere they are masked off so
  // no yumi can escape mid-transaction.
  assign pick_valid = {req1_in.valid, req0_in.valid} & {2{state_q == IDLE}};

  rr_pick2 u_pick (
    .valid_i (pick_valid),
    .last_i  (last_q),
    .grant_o (pick_grant),
    .any_o   (pick_any)
  );

  logic owner_yumi;
  logic mem_take;

  assign owner_yumi = owner_q ? req1_in.yumi : req0_in.yumi;
  assign mem_take   = (state_q == WAIT) && mem_rsp.valid;

  // Writes report zero; reads pass memory data through untouched.
  assign rdata_d = wen_q ? '0 : mem_rsp.read_data;

  // Transaction sequencer: latch the winner, issue, collect, hand back.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      bnw_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            owner_q <= pick_grant[1];
            addr_q  <= pick_grant[1] ? req1_addr_i : req0_addr_i;
            wen_q   <= pick_grant[1] ? req1_in.wen : req0_in.wen;
            bnw_q   <= pick_grant[1] ? req1_in.byte_not_word : req0_in.byte_not_word;
            wdata_q <= pick_grant[1] ? req1_in.write_data : req0_in.write_data;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_rsp.yumi) begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (mem_rsp.valid) begin
            rdata_q <= rdata_d;
            state_q <= RETURN;
          end
        end
        RETURN: begin
          if (owner_yumi) begin
            last_q  <= owner_q;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  mem_in_s  mem_req;
  mem_out_s rsp0;
  mem_out_s rsp1;

  // Memory-side port: valid only in ISSUE, latched fields always visible.
  always_comb begin
    mem_req               = '0;
    mem_req.valid         = (state_q == ISSUE);
    mem_req.wen           = wen_q;
    mem_req.byte_not_word = bnw_q;
    mem_req.write_data    = wdata_q;
    mem_req.yumi          = mem_take;
  end

  // Requester responses: only the owner sees valid/data, and only in RETURN.
  always_comb begin
    rsp0      = '0;
    rsp1      = '0;
    rsp0.yumi = pick_grant[0];
    rsp1.yumi = pick_grant[1];
    if (state_q == RETURN) begin
      if (owner_q) begin
        rsp1.valid     = 1'b1;
        rsp1.read_data = rdata_q;
      end else begin
        rsp0.valid     = 1'b1;
        rsp0.read_data = rdata_q;
      end
    end
  end

  // Current owner as one-hot; idle shows no owner.
  always_comb begin
    grant_o = 2'b00;
    if (state_q != IDLE) begin
      grant_o = owner_q ? 2'b10 : 2'b01;
    end
  end

  assign mem_flat_o  = mem_req;
  assign mem_addr_o  = addr_q;
  assign req0_flat_o = rsp0;
  assign req1_flat_o = rsp1;

endmodule
`default_nettype wire
